// File: rtl/vga_buf_reader_if.sv
// Read-port and video-output bundle of the frame-buffer scan-out stage.
// The reader drives the master side; the RAM port and display sink sit on the slave side.
interface vga_buf_reader_if #(
    parameter int P_DATA_W         = 8,
    parameter int P_LOG2_RAM_DEPTH = 15
);
    logic [P_LOG2_RAM_DEPTH-1:0] o_rd_addr;
    logic [P_DATA_W-1:0]         i_rd_data;
    logic [P_DATA_W-1:0]         o_pixel;
    logic                        o_de;
    logic                        o_hsync;
    logic                        o_vsync;
    logic                        o_frame_start;

    modport master (
        output o_rd_addr,
        input  i_rd_data,
        output o_pixel,
        output o_de,
        output o_hsync,
        output o_vsync,
        output o_frame_start
    );

    modport slave (
        input  o_rd_addr,
        output i_rd_data,
        input  o_pixel,
        input  o_de,
        input  o_hsync,
        input  o_vsync,
        input  o_frame_start
    );
endinterface

// File: rtl/vga_buf_reader.sv
// VGA scan-out from the frame buffer: raster timing, pixel-replicating read addresses,
// and a 2-stage aligned output pipeline matching the 1-cycle registered RAM read.
module vga_buf_reader #(
    parameter int P_DATA_W         = 8,
    parameter int P_LOG2_RAM_DEPTH = 15,
    parameter int P_IMG_W          = 160,
    parameter int P_IMG_H          = 120,
    parameter int P_LOG2_SCALE     = 2,
    parameter int P_H_ACTIVE       = 640,
    parameter int P_H_FP           = 16,
    parameter int P_H_SYNC         = 96,
    parameter int P_H_BP           = 48,
    parameter int P_V_ACTIVE       = 480,
    parameter int P_V_FP           = 10,
    parameter int P_V_SYNC         = 2,
    parameter int P_V_BP           = 33
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    vga_buf_reader_if.master bus
);
    localparam int H_TOTAL = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int V_TOTAL = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int SUB_W   = (P_LOG2_SCALE > 0) ? P_LOG2_SCALE : 1;
    localparam int AW      = P_LOG2_RAM_DEPTH;

    localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT_END  = H_W'(P_H_ACTIVE);
    localparam logic [H_W-1:0]   H_ACT_LAST = H_W'(P_H_ACTIVE - 1);
    localparam logic [H_W-1:0]   HS_START   = H_W'(P_H_ACTIVE + P_H_FP);
    localparam logic [H_W-1:0]   HS_END     = H_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
    localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_ACT_END  = V_W'(P_V_ACTIVE);
    localparam logic [V_W-1:0]   VS_START   = V_W'(P_V_ACTIVE + P_V_FP);
    localparam logic [V_W-1:0]   VS_END     = V_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC);
    localparam logic [SUB_W-1:0] SUB_MAX    = SUB_W'((1 << P_LOG2_SCALE) - 1);
    localparam logic [AW-1:0]    IMG_W_C    = AW'(P_IMG_W);
    localparam logic [AW-1:0]    LAST_BASE  = AW'((P_IMG_H - 1) * P_IMG_W);
    localparam logic [P_DATA_W-1:0] PIX_BLANK = '0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           state_r, next_state_s;
    logic [H_W-1:0]   h_cnt_r;
    logic [V_W-1:0]   v_cnt_r;
    logic [SUB_W-1:0] sub_x_r, sub_y_r;
    logic [AW-1:0]    line_base_r;
    logic             scan_s, frame_wrap_s, active_s;
    logic             hsync_s, vsync_s, frame_start_s;
    logic             de_d1_r, hs_d1_r, vs_d1_r, fs_d1_r;

    // Raster decode of the current counter position.
    always_comb begin
        scan_s        = (state_r == ST_SCAN);
        frame_wrap_s  = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
        active_s      = scan_s && (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
        hsync_s       = !(scan_s && (h_cnt_r >= HS_START) && (h_cnt_r < HS_END));
        vsync_s       = !(scan_s && (v_cnt_r >= VS_START) && (v_cnt_r < VS_END));
        frame_start_s = scan_s && (h_cnt_r == '0) && (v_cnt_r == '0);
    end

    // Scan state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Scan may only stop at a frame boundary so the display never sees a truncated frame.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_en) next_state_s = ST_SCAN;
                else      next_state_s = ST_IDLE;
            end
            ST_SCAN: begin
                if (frame_wrap_s && !i_en) next_state_s = ST_IDLE;
                else                       next_state_s = ST_SCAN;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Horizontal and vertical position counters; held at the origin while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (!scan_s) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= '0;
            v_cnt_r <= (v_cnt_r == V_LAST) ? '0 : v_cnt_r + V_W'(1);
        end else begin
            h_cnt_r <= h_cnt_r + H_W'(1);
        end
    end

    // Read address tracks the next counter position; the last stored row never advances
    // line_base, so vertical blanking keeps a valid in-image address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_rd_addr <= '0;
            line_base_r   <= '0;
            sub_x_r       <= '0;
            sub_y_r       <= '0;
        end else if (!scan_s || frame_wrap_s) begin
            bus.o_rd_addr <= '0;
            line_base_r   <= '0;
            sub_x_r       <= '0;
            sub_y_r       <= '0;
        end else if (active_s && (h_cnt_r == H_ACT_LAST)) begin
            sub_x_r <= '0;
            if ((sub_y_r == SUB_MAX) && (line_base_r != LAST_BASE)) begin
                sub_y_r       <= '0;
                line_base_r   <= line_base_r + IMG_W_C;
                bus.o_rd_addr <= line_base_r + IMG_W_C;
            end else begin
                sub_y_r       <= (sub_y_r == SUB_MAX) ? '0 : sub_y_r + SUB_W'(1);
                bus.o_rd_addr <= line_base_r;
            end
        end else if (active_s) begin
            if (sub_x_r == SUB_MAX) begin
                sub_x_r       <= '0;
                bus.o_rd_addr <= bus.o_rd_addr + AW'(1);
            end else begin
                sub_x_r       <= sub_x_r + SUB_W'(1);
            end
        end else begin
            bus.o_rd_addr <= line_base_r;
        end
    end

    // Two-stage delay of the timing flags so they line up with the RAM read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            de_d1_r           <= 1'b0;
            hs_d1_r           <= 1'b1;
            vs_d1_r           <= 1'b1;
            fs_d1_r           <= 1'b0;
            bus.o_de          <= 1'b0;
            bus.o_hsync       <= 1'b1;
            bus.o_vsync       <= 1'b1;
            bus.o_frame_start <= 1'b0;
            bus.o_pixel       <= PIX_BLANK;
        end else begin
            de_d1_r           <= active_s;
            hs_d1_r           <= hsync_s;
            vs_d1_r           <= vsync_s;
            fs_d1_r           <= frame_start_s;
            bus.o_de          <= de_d1_r;
            bus.o_hsync       <= hs_d1_r;
            bus.o_vsync       <= vs_d1_r;
            bus.o_frame_start <= fs_d1_r;
            bus.o_pixel       <= de_d1_r ? bus.i_rd_data : PIX_BLANK;
        end
    end
endmodule

// File: tb/tb_vga_buf_reader.sv
// Scoreboard bench for vga_buf_reader on a tiny 14x7 raster with a registered RAM model.
module tb_vga_buf_reader;
    localparam int DW = 8, AW = 3, IMG_W = 4, IMG_H = 2, S = 1;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic          de;
        logic          hs;
        logic          vs;
        logic          fs;
        logic [DW-1:0] pix;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_en;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    vga_buf_reader_if #(.P_DATA_W(DW), .P_LOG2_RAM_DEPTH(AW)) bus ();

    vga_buf_reader #(
        .P_DATA_W(DW), .P_LOG2_RAM_DEPTH(AW), .P_IMG_W(IMG_W), .P_IMG_H(IMG_H),
        .P_LOG2_SCALE(S),
        .P_H_ACTIVE(HA), .P_H_FP(HF), .P_H_SYNC(HS), .P_H_BP(HB),
        .P_V_ACTIVE(VA), .P_V_FP(VF), .P_V_SYNC(VS), .P_V_BP(VB)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_en   (i_en),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    // dp_ram port B: registered read, one cycle after the address
    always @(posedge i_clk) bus.i_rd_data <= mem[bus.o_rd_addr];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   fs_count = 0;
    int   m_h, m_v;
    logic m_scan;
    exp_t sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic int model_addr();
        if (!m_scan) return 0;
        if (m_v < VA && m_h < HA) return (m_v >> S) * IMG_W + (m_h >> S);
        if (m_v < VA && ((m_v + 1) % (1 << S)) == 0 && (m_v + 1) < VA)
            return ((m_v + 1) >> S) * IMG_W;
        if (m_v < VA) return (m_v >> S) * IMG_W;
        return ((VA - 1) >> S) * IMG_W;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.de  = m_scan && (m_h < HA) && (m_v < VA);
        e.hs  = !(m_scan && (m_h >= HA + HF) && (m_h < HA + HF + HS));
        e.vs  = !(m_scan && (m_v >= VA + VF) && (m_v < VA + VF + VS));
        e.fs  = m_scan && (m_h == 0) && (m_v == 0);
        e.pix = e.de ? DW'(32'h10 + model_addr()) : '0;
        return e;
    endfunction

    task automatic model_step(input logic en);
        if (!m_scan) begin
            m_scan = en;
            m_h    = 0;
            m_v    = 0;
        end else if (m_h == HT - 1) begin
            m_h = 0;
            if (m_v == VT - 1) begin
                m_v = 0;
                if (!en) m_scan = 1'b0;
            end else begin
                m_v++;
            end
        end else begin
            m_h++;
        end
    endtask

    // One pixel clock: compare outputs of two cycles ago, check the address, push, advance.
    task automatic cycle(input logic en);
        exp_t e;
        @(negedge i_clk);
        if (bus.o_frame_start) fs_count++;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val("de",          32'(bus.o_de),          32'(e.de));
            check_val("hsync",       32'(bus.o_hsync),       32'(e.hs));
            check_val("vsync",       32'(bus.o_vsync),       32'(e.vs));
            check_val("frame_start", 32'(bus.o_frame_start), 32'(e.fs));
            check_val("pixel",       32'(bus.o_pixel),       32'(e.pix));
        end
        check_val("rd_addr", 32'(bus.o_rd_addr), 32'(model_addr()));
        sb_q.push_back(model_exp());
        i_en = en;
        model_step(en);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rd_addr"}, 32'(bus.o_rd_addr),     32'd0);
        check_val({tag, "_pixel"},   32'(bus.o_pixel),       32'd0);
        check_val({tag, "_de"},      32'(bus.o_de),          32'd0);
        check_val({tag, "_hsync"},   32'(bus.o_hsync),       32'd1);
        check_val({tag, "_vsync"},   32'(bus.o_vsync),       32'd1);
        check_val({tag, "_fs"},      32'(bus.o_frame_start), 32'd0);
    endtask

    // Called at a falling edge: the pipeline holds idle values for the next two samples.
    task automatic release_reset();
        i_rst_n = 1'b1;
        m_scan  = 1'b0;
        m_h     = 0;
        m_v     = 0;
        sb_q.delete();
        sb_q.push_back(model_exp());
        sb_q.push_back(model_exp());
        model_step(i_en);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(32'h10 + i);
        i_rst_n = 1'b0;
        i_en    = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("por");
        release_reset();

        repeat (30) cycle(1'b0);

        fs_count = 0;
        repeat (HT * VT + 40) cycle(1'b1);
        repeat (HT * VT + 20) cycle(1'b0);
        check_val("fs_pulses_drop", 32'(fs_count), 32'd2);

        repeat (2 * HT + 3) cycle(1'b1);
        #2 i_rst_n = 1'b0;
        #1 check_reset_outputs("async");
        repeat (3) begin
            @(negedge i_clk);
            check_reset_outputs("hold");
        end
        fs_count = 0;
        release_reset();
        repeat (HT * VT + 2) cycle(1'b1);
        check_val("fs_pulses_restart", 32'(fs_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
